psum_buffer: RTL



---
 rtl/psum_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/psum_buffer.sv
// Partial-sum buffer: PE read/write port (1-cycle read) plus a clear-on-read drain that scales, saturates and streams out.
// Drain latency 2 cycles issue->out_valid; drain reads are issued only while FIFO + in-flight < 2, so out_ready stalls never lose a beat.
module psum_buffer #(
    parameter int DEPTH = 256,
    parameter int LANES = 4,
    parameter int PW    = 40,
    parameter int OW    = 16,
    parameter int SHIFT = 8,
    parameter int AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [AW-1:0]         ra,
    output logic [LANES*PW-1:0]   rd,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [LANES*PW-1:0]   wd,
    input  logic                  drain_start,
    input  logic [AW-1:0]         drain_base,
    input  logic [AW-1:0]         drain_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OW-1:0]   out_data,
    output logic                  out_last,
    output logic                  buf_ready,
    output logic                  drain_done
);
    typedef enum logic [1:0] {S_INIT_CLR, S_IDLE, S_DRAIN, S_DRAIN_WAIT} state_t;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [LANES*PW-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_addr_q, clr_addr_d;
    logic [AW-1:0]         base_q, base_d, len_q, len_d, cnt_q, cnt_d;
    logic                  inflight_q, inflight_d, ilast_q, ilast_d;
    logic [LANES*PW-1:0]   drd_q, drd_d, rd_q, rd_d;
    logic [LANES*OW-1:0]   fifo_dat_q [2];
    logic [LANES*OW-1:0]   fifo_dat_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic                  issue, mem_clr_en, pe_en, push, pop;
    logic [AW-1:0]         mem_clr_addr, drain_addr;
    logic [LANES*OW-1:0]   proc_dat;

    function automatic logic [OW-1:0] sat_lane(input logic [PW-1:0] raw);
        logic signed [PW-1:0] s;
        s = $signed(raw) >>> SHIFT;
        if (s > SAT_MAX)      sat_lane = SAT_MAX[OW-1:0];
        else if (s < SAT_MIN) sat_lane = SAT_MIN[OW-1:0];
        else                  sat_lane = s[OW-1:0];
    endfunction

    assign drain_addr = base_q + cnt_q;
    assign pe_en      = (state_q != S_INIT_CLR);
    assign out_valid  = (fifo_cnt_q != 2'd0);
    assign out_data   = out_valid ? fifo_dat_q[fifo_rp_q] : '0;
    assign out_last   = out_valid & fifo_last_q[fifo_rp_q];
    assign buf_ready  = (state_q == S_IDLE);
    assign push       = inflight_q;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        mem_clr_en   = 1'b0;
        mem_clr_addr = clr_addr_q;
        drain_done   = 1'b0;
        case (state_q)
            S_INIT_CLR: begin
                mem_clr_en = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {AW{1'b1}}) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (drain_start) begin
                    base_d  = drain_base;
                    len_d   = drain_len;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Credit check ignores a same-cycle pop: one slot of slack keeps this off the out_ready path.
                if (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2) begin
                    issue        = 1'b1;
                    mem_clr_en   = 1'b1;
                    mem_clr_addr = drain_addr;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == len_q) state_d = S_DRAIN_WAIT;
                end
            end
            S_DRAIN_WAIT: begin
                if (fifo_cnt_q == 2'd0 && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_INIT_CLR;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        ilast_d    = issue && (cnt_q == len_q);
        drd_d      = issue ? mem[drain_addr] : drd_q;
        rd_d       = rd_q;
        if (pe_en && re) rd_d = (we && wa == ra) ? wd : mem[ra];
        for (int i = 0; i < LANES; i++) proc_dat[i*OW +: OW] = sat_lane(drd_q[i*PW +: PW]);
    end

    always_comb begin
        fifo_dat_d  = fifo_dat_q;
        fifo_last_d = fifo_last_q;
        fifo_wp_d   = fifo_wp_q;
        fifo_rp_d   = fifo_rp_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push) begin
            fifo_dat_d[fifo_wp_q]  = proc_dat;
            fifo_last_d[fifo_wp_q] = ilast_q;
            fifo_wp_d              = ~fifo_wp_q;
        end
        if (pop) fifo_rp_d = ~fifo_rp_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // PE write is applied after the clear so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (mem_clr_en)     mem[mem_clr_addr] <= '0;
        if (pe_en && we)    mem[wa] <= wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT_CLR;
            clr_addr_q  <= '0;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            ilast_q     <= 1'b0;
            drd_q       <= '0;
            rd_q        <= '0;
            fifo_dat_q  <= '{default: '0};
            fifo_last_q <= '0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            ilast_q     <= ilast_d;
            drd_q       <= drd_d;
            rd_q        <= rd_d;
            fifo_dat_q  <= fifo_dat_d;
            fifo_last_q <= fifo_last_d;
            fifo_wp_q   <= fifo_wp_d;
            fifo_rp_q   <= fifo_rp_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign rd = rd_q;
endmodule
